// File: rtl/hnm_query_reader.sv
// hnm_query_reader: answers SSID queries against the HNM hit map through BRAM port B.
// Each accepted query issues one row read and carries its column through a pipe that
// matches the BRAM latency. The column bit is then picked from the returned word and
// pushed with its SSID into a small in-order result FIFO.
// A credit count covers reads in flight plus queued results, so the FIFO never overflows.
// Optional build macro HNM_QUERY_STATS_EN adds saturating query/hit counters.
module hnm_query_reader #(
   parameter int SSIDBITS       = 12,
   parameter int COLINDEXBITS   = 5,
   parameter int NCOLS          = 32,
   parameter int ROWINDEXBITS   = SSIDBITS - COLINDEXBITS,
   parameter int BRAM_READDELAY = 2,
   parameter int OUTFIFO_DEPTH  = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    hnm_ready,
   input  logic                    query_valid,
   input  logic [SSIDBITS-1:0]     query_ssid,
   output logic                    query_ready,
   output logic                    bram_rd,
   output logic [ROWINDEXBITS-1:0] bram_addr,
   input  logic [NCOLS-1:0]        bram_dout,
   output logic                    result_valid,
   output logic [SSIDBITS-1:0]     result_ssid,
   output logic                    result_hit,
   input  logic                    result_ready
`ifdef HNM_QUERY_STATS_EN
   ,
   output logic [15:0]             stat_queries,
   output logic [15:0]             stat_hits
`endif
);

   localparam int CREDITBITS = $clog2(OUTFIFO_DEPTH + 1);
   localparam int PTRBITS    = $clog2(OUTFIFO_DEPTH);
   localparam logic [CREDITBITS-1:0] CREDITMAX = CREDITBITS'(OUTFIFO_DEPTH);

   logic [CREDITBITS-1:0] creditCount;
   logic [CREDITBITS-1:0] fifoCount;
   logic [PTRBITS-1:0]    rdPtr;
   logic [PTRBITS-1:0]    wrPtr;
   logic                  accept;
   logic                  pop;
   logic                  push;
   logic                  pushHit;

   logic                  pipeValid [BRAM_READDELAY];
   logic [SSIDBITS-1:0]   pipeSsid  [BRAM_READDELAY];

   logic [SSIDBITS-1:0]   fifoSsid  [OUTFIFO_DEPTH];
   logic                  fifoHit   [OUTFIFO_DEPTH];

   assign query_ready  = !reset && hnm_ready && (creditCount < CREDITMAX);
   assign accept       = query_valid && query_ready;
   assign result_valid = (fifoCount != '0);
   assign pop          = result_valid && result_ready;
   assign push         = pipeValid[BRAM_READDELAY-1];
   assign pushHit      = bram_dout[pipeSsid[BRAM_READDELAY-1][COLINDEXBITS-1:0]];
   assign result_ssid  = result_valid ? fifoSsid[rdPtr] : '0;
   assign result_hit   = result_valid ? fifoHit[rdPtr] : 1'b0;

   // Credits track reads in flight plus queued results; accept adds one, pop frees one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         creditCount <= '0;
      end else begin
         case ({accept, pop})
            2'b10:   creditCount <= creditCount + CREDITBITS'(1);
            2'b01:   creditCount <= creditCount - CREDITBITS'(1);
            default: creditCount <= creditCount;
         endcase
      end
   end

   // Read issue: one-cycle read strobe per accept, row address holds between reads.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bram_rd   <= 1'b0;
         bram_addr <= '0;
      end else begin
         bram_rd <= accept;
         if (accept) begin
            bram_addr <= query_ssid[SSIDBITS-1:COLINDEXBITS];
         end
      end
   end

   // Shift pipe that delivers each SSID alongside its BRAM word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < BRAM_READDELAY; i++) begin
            pipeValid[i] <= 1'b0;
            pipeSsid[i]  <= '0;
         end
      end else begin
         pipeValid[0] <= accept;
         pipeSsid[0]  <= query_ssid;
         for (int i = 1; i < BRAM_READDELAY; i++) begin
            pipeValid[i] <= pipeValid[i-1];
            pipeSsid[i]  <= pipeSsid[i-1];
         end
      end
   end

   // Result FIFO storage; contents are don't-care until counted as occupied.
   always_ff @(posedge clk) begin
      if (push) begin
         fifoSsid[wrPtr] <= pipeSsid[BRAM_READDELAY-1];
         fifoHit[wrPtr]  <= pushHit;
      end
   end

   // Result FIFO pointers and occupancy; push and pop on the same edge leave occupancy unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         fifoCount <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + PTRBITS'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + PTRBITS'(1);
         end
         case ({push, pop})
            2'b10:   fifoCount <= fifoCount + CREDITBITS'(1);
            2'b01:   fifoCount <= fifoCount - CREDITBITS'(1);
            default: fifoCount <= fifoCount;
         endcase
      end
   end

`ifdef HNM_QUERY_STATS_EN
   // Saturating counters of accepted queries and of results that hit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_queries <= '0;
         stat_hits    <= '0;
      end else begin
         if (accept && (stat_queries != 16'hFFFF)) begin
            stat_queries <= stat_queries + 16'd1;
         end
         if (push && pushHit && (stat_hits != 16'hFFFF)) begin
            stat_hits <= stat_hits + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hnm_query_reader.sv
// tb_hnm_query_reader: directed bench for hnm_query_reader with a scoreboard.
// Queries push their hand-computed {ssid, hit} into a queue when accepted. A monitor
// pops and compares on every result handshake. Runs the stats test when
// HNM_QUERY_STATS_EN is defined.
module tb_hnm_query_reader;

   typedef struct {
      logic [11:0] ssid;
      logic        hit;
   } expT;

   logic        clk;
   logic        reset;
   logic        hnm_ready;
   logic        query_valid;
   logic [11:0] query_ssid;
   logic        query_ready;
   logic        bram_rd;
   logic [6:0]  bram_addr;
   logic [31:0] bram_dout;
   logic        result_valid;
   logic [11:0] result_ssid;
   logic        result_hit;
   logic        result_ready;
`ifdef HNM_QUERY_STATS_EN
   logic [15:0] stat_queries;
   logic [15:0] stat_hits;
`endif

   logic [31:0] mem [128];
   logic [31:0] bramData;
   expT         expQ [$];
   int          popCycles [$];
   int          checkCount = 0;
   int          passCount  = 0;
   int          popCount   = 0;
   int          cycleCount = 0;
   bit          monitorOn  = 1'b1;

   hnm_query_reader dut (
      .clk          (clk),
      .reset        (reset),
      .hnm_ready    (hnm_ready),
      .query_valid  (query_valid),
      .query_ssid   (query_ssid),
      .query_ready  (query_ready),
      .bram_rd      (bram_rd),
      .bram_addr    (bram_addr),
      .bram_dout    (bram_dout),
      .result_valid (result_valid),
      .result_ssid  (result_ssid),
      .result_hit   (result_hit),
      .result_ready (result_ready)
`ifdef HNM_QUERY_STATS_EN
      ,
      .stat_queries (stat_queries),
      .stat_hits    (stat_hits)
`endif
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // BRAM port B model: word for bram_addr appears one edge later and is sampled one edge after that.
   always @(posedge clk) begin
      bramData <= mem[bram_addr];
      cycleCount++;
   end
   assign bram_dout = bramData;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Offer one query for up to maxWait cycles; record the expected result on acceptance.
   task automatic applyStimulus(input logic [11:0] ssid, input logic expHit, input int maxWait,
                                output bit accepted);
      expT e;
      accepted    = 1'b0;
      query_valid = 1'b1;
      query_ssid  = ssid;
      for (int i = 0; i < maxWait && !accepted; i++) begin
         @(negedge clk);
         if (query_ready) begin
            accepted = 1'b1;
            e.ssid   = ssid;
            e.hit    = expHit;
            expQ.push_back(e);
         end
         @(posedge clk);
         #1;
      end
      query_valid = 1'b0;
   endtask

   task automatic waitDrain(input string name, input int maxCycles);
      int n = 0;
      while (expQ.size() != 0 && n < maxCycles) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput(name, expQ.size(), 0);
   endtask

   // Monitor: every result handshake is compared against the oldest expected entry.
   always @(negedge clk) begin
      expT e;
      if (!reset && monitorOn && result_valid && result_ready) begin
         popCount++;
         popCycles.push_back(cycleCount);
         if (expQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL unexpected_result: got ssid 0x%0h hit %0d, expected no result",
                     result_ssid, result_hit);
         end else begin
            e = expQ.pop_front();
            checkOutput("result_ssid", result_ssid, e.ssid);
            checkOutput("result_hit", result_hit, e.hit);
         end
      end
   end

   initial begin
      bit          acc;
      int          accCount;
      int          popsBefore;
      logic [5:0]  hitPattern;

      for (int i = 0; i < 128; i++) mem[i] = 32'h0;
      reset        = 1'b1;
      hnm_ready    = 1'b1;
      query_valid  = 1'b0;
      query_ssid   = 12'h000;
      result_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_query_ready", query_ready, 0);
      checkOutput("reset_result_valid", result_valid, 0);
      checkOutput("reset_bram_rd", bram_rd, 0);
      checkOutput("reset_bram_addr", bram_addr, 0);
      checkOutput("reset_result_ssid", result_ssid, 0);
      checkOutput("reset_result_hit", result_hit, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("ready_after_reset", query_ready, 1);
      @(posedge clk);
      #1;

      // First query, all-zero map: latency and read strobe
      applyStimulus(12'h000, 1'b0, 10, acc);
      checkOutput("q0_accepted", acc, 1);
      @(negedge clk);
      checkOutput("q0_bram_rd", bram_rd, 1);
      checkOutput("q0_bram_addr", bram_addr, 7'h00);
      checkOutput("q0_valid_early1", result_valid, 0);
      @(negedge clk);
      checkOutput("q0_bram_rd_drop", bram_rd, 0);
      checkOutput("q0_valid_early2", result_valid, 0);
      @(negedge clk);
      checkOutput("q0_valid_latency", result_valid, 1);
      waitDrain("q0_drain", 20);

      // Back-to-back queries on row 5 (bits 1,3,5,8 set)
      mem[5] = 32'h0000_012A;
      popCycles.delete();
      applyStimulus(12'h0A8, 1'b1, 10, acc);
      applyStimulus(12'h0A9, 1'b0, 10, acc);
      waitDrain("b2b_drain", 20);
      checkOutput("b2b_consecutive", (popCycles.size() == 2) ? (popCycles[1] - popCycles[0]) : -1, 1);

      // Backpressure: only OUTFIFO_DEPTH queries fit while results are not consumed
      hitPattern   = 6'b101010;
      result_ready = 1'b0;
      accCount     = 0;
      popsBefore   = popCount;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(12'h0A0 + 12'(i), hitPattern[i], 1, acc);
         if (acc) accCount++;
      end
      checkOutput("bp_accept_count", accCount, 4);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("bp_query_ready", query_ready, 0);
      checkOutput("bp_head_ssid", result_ssid, 12'h0A0);
      @(negedge clk);
      checkOutput("bp_head_stable", result_ssid, 12'h0A0);
      @(posedge clk);
      #1;
      result_ready = 1'b1;
      applyStimulus(12'h0A4, hitPattern[4], 20, acc);
      checkOutput("bp_late_accept4", acc, 1);
      applyStimulus(12'h0A5, hitPattern[5], 20, acc);
      checkOutput("bp_late_accept5", acc, 1);
      waitDrain("bp_drain", 30);
      checkOutput("bp_pop_count", popCount - popsBefore, 6);

      // All-ones SSID maps to last row, top bit
      mem[7'h7F] = 32'h8000_0000;
      applyStimulus(12'hFFF, 1'b1, 10, acc);
      @(negedge clk);
      checkOutput("wrap_bram_addr", bram_addr, 7'h7F);
      waitDrain("wrap_drain", 20);

      // hnm_ready drops with two reads in flight
      applyStimulus(12'h0A1, 1'b1, 10, acc);
      applyStimulus(12'h0A3, 1'b1, 10, acc);
      hnm_ready = 1'b0;
      @(negedge clk);
      checkOutput("hnm_drop_query_ready", query_ready, 0);
      checkOutput("hnm_drop_pending", expQ.size(), 2);
      waitDrain("hnm_drop_drain", 20);
      hnm_ready = 1'b1;
      @(posedge clk);
      #1;

      // Reset with one result queued and one read in flight
      result_ready = 1'b0;
      applyStimulus(12'h0A1, 1'b1, 10, acc);
      applyStimulus(12'h0A3, 1'b1, 10, acc);
      @(posedge clk);
      #1;
      reset = 1'b1;
      expQ.delete();
      @(negedge clk);
      checkOutput("mid_reset_result_valid", result_valid, 0);
      checkOutput("mid_reset_query_ready", query_ready, 0);
      @(posedge clk);
      #1;
      reset        = 1'b0;
      result_ready = 1'b1;
      popsBefore   = popCount;
      repeat (10) @(posedge clk);
      @(negedge clk);
      checkOutput("post_reset_no_results", popCount - popsBefore, 0);
      checkOutput("post_reset_valid", result_valid, 0);

`ifdef HNM_QUERY_STATS_EN
      // Saturation of the statistics counters
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset     = 1'b0;
      monitorOn = 1'b0;
      query_ssid  = 12'h0A8;
      query_valid = 1'b1;
      repeat (70000) @(posedge clk);
      #1;
      query_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      checkOutput("stat_queries_sat", stat_queries, 16'hFFFF);
      checkOutput("stat_hits_sat", stat_hits, 16'hFFFF);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/hnm_query_reader.md
Name: hnm_query_reader

Overview:
Read-side companion to the HNM hit-map writer/clearer. Accepts SSID queries from downstream pattern logic and splits each into row and column. Issues reads on the HNM BRAM read port, extracts the column bit after the BRAM latency and returns an ordered {SSID, hit} result stream with backpressure. Sits between the HNM BRAM port B and the road-finding logic.

Parameters:
SSIDBITS, 12, query SSID width
COLINDEXBITS, 5, low SSID bits selecting the column; must satisfy 2**COLINDEXBITS == NCOLS
NCOLS, 32, BRAM word width (hit bits per row)
ROWINDEXBITS, SSIDBITS-COLINDEXBITS, BRAM row address width
BRAM_READDELAY, 2, cycles from bram_rd edge to valid bram_dout; range 1..4
OUTFIFO_DEPTH, 4, result FIFO entries; must be >= BRAM_READDELAY+1 and a power of 2

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
hnm_ready  in  1  HNM read-ready from the writer block; high = map contents valid
query_valid  in  1  query request
query_ssid  in  SSIDBITS  SSID to test; upper ROWINDEXBITS = row, lower COLINDEXBITS = column
query_ready  out  1  query accepted on edge where query_valid && query_ready
bram_rd  out  1  registered read enable to BRAM port B
bram_addr  out  ROWINDEXBITS  registered read row
bram_dout  in  NCOLS  BRAM read data
result_valid  out  1  FIFO head valid
result_ssid  out  SSIDBITS  SSID of head result
result_hit  out  1  1 = SSID bit set in map
result_ready  in  1  consumer pop; pop on result_valid && result_ready

Behaviour:
- Async reset: bram_rd=0, bram_addr=0, result_valid=0, result_ssid=0, result_hit=0, FIFO empty, pipeline valids 0, credit count 0. query_ready=0 while reset is high.
- Credits: count = in-flight reads + FIFO occupancy, range 0..OUTFIFO_DEPTH. count+1 on accept, count-1 on pop, unchanged on simultaneous accept and pop.
- query_ready = hnm_ready && (count < OUTFIFO_DEPTH). Combinational from registers only; no path from query_valid.
- Accept at edge N: bram_rd=1 and bram_addr=row from edge N. {ssid, col} enters a BRAM_READDELAY-deep valid-tagged shift pipe. Without an accept, bram_rd=0 and bram_addr holds its value.
- At pipe output (edge N+BRAM_READDELAY): hit = bram_dout[col]; push {ssid, hit} into FIFO. Credits guarantee no overflow, so the push is never dropped.
- result_* driven from FIFO head. result_valid=1 the cycle after the push into an empty FIFO. Min query-to-result latency = BRAM_READDELAY+1 cycles.
- Throughput: 1 query/cycle sustained while result_ready=1.
- Ordering: results leave strictly in acceptance order.
- FIFO full and pop with push on the same edge: both happen, occupancy unchanged.
- hnm_ready falls mid-operation: no new accepts. Reads already issued complete and deliver results.
- hnm_ready low with FIFO non-empty: FIFO still drains normally.
- Row/column wrap: all-ones SSID maps to the last row, bit NCOLS-1. No address arithmetic beyond bit slicing.
- result_ready=0 with FIFO full: query_ready=0. Output holds stable until popped.
- Reset mid-operation: in-flight reads and queued results are discarded. No result is emitted for them after reset releases.

Optional Feature:
HNM_QUERY_STATS_EN
- Defined: adds outputs stat_queries[15:0] and stat_hits[15:0]. They are 16-bit saturating counters of accepted queries and of pushed results with hit=1. Both clear on reset and hold at 16'hFFFF.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset release with hnm_ready=1, BRAM all-zero; query SSID 0x000 -> bram_addr=0x00 with bram_rd for 1 cycle; result_valid at accept+3 with result_ssid=0x000, result_hit=0.
- BRAM row 0x05 = 0x0000_0100; queries 0x0A8 then 0x0A9 back-to-back -> results in order: (0x0A8, hit=1) then (0x0A9, hit=0) on consecutive cycles.
- result_ready=0, 6 queries offered -> exactly 4 accepted, then query_ready=0. result_ready=1 -> 4 results popped in order, then the remaining 2 are accepted.
- SSID 0xFFF with row 0x7F = 0x8000_0000 -> bram_addr=0x7F, result_hit=1.
- 2 queries in flight, hnm_ready drops -> query_ready=0 next cycle and both results still delivered. Repeat with reset asserted instead -> result_valid=0 and no results appear after release.
- HNM_QUERY_STATS_EN defined: 70000 hitting queries -> stat_queries=stat_hits=0xFFFF (saturated).
